// File: rtl/cv32e40x_xif_aes_buf_if.sv
// eXtension-interface bundle: issue, commit and result channels between core and coprocessor.
// The coproc_* modports face the coprocessor and the cpu_* modports face the core.
interface if_xif #(
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFR_WIDTH = 32
);
    logic                   issue_valid;
    logic                   issue_ready;
    logic [31:0]            issue_req_instr;
    logic [X_RFR_WIDTH-1:0] issue_req_rs [2];
    logic [1:0]             issue_req_rs_valid;
    logic [X_ID_WIDTH-1:0]  issue_req_id;
    logic                   issue_resp_accept;
    logic                   issue_resp_writeback;
    logic                   issue_resp_dualwrite;
    logic                   issue_resp_dualread;
    logic                   issue_resp_loadstore;
    logic                   issue_resp_ecswrite;
    logic                   issue_resp_exc;

    logic                   commit_valid;
    logic [X_ID_WIDTH-1:0]  commit_id;
    logic                   commit_kill;

    logic                   result_valid;
    logic                   result_ready;
    logic [X_ID_WIDTH-1:0]  result_id;
    logic [X_RFR_WIDTH-1:0] result_data;
    logic [4:0]             result_rd;
    logic                   result_we;

    modport coproc_issue (
        input  issue_valid, issue_req_instr, issue_req_rs, issue_req_rs_valid, issue_req_id,
        output issue_ready, issue_resp_accept, issue_resp_writeback, issue_resp_dualwrite,
               issue_resp_dualread, issue_resp_loadstore, issue_resp_ecswrite, issue_resp_exc
    );
    modport cpu_issue (
        output issue_valid, issue_req_instr, issue_req_rs, issue_req_rs_valid, issue_req_id,
        input  issue_ready, issue_resp_accept, issue_resp_writeback, issue_resp_dualwrite,
               issue_resp_dualread, issue_resp_loadstore, issue_resp_ecswrite, issue_resp_exc
    );
    modport coproc_commit (input  commit_valid, commit_id, commit_kill);
    modport cpu_commit    (output commit_valid, commit_id, commit_kill);
    modport coproc_result (
        output result_valid, result_id, result_data, result_rd, result_we,
        input  result_ready
    );
    modport cpu_result (
        input  result_valid, result_id, result_data, result_rd, result_we,
        output result_ready
    );
endinterface

// File: rtl/cv32e40x_xif_aes_buf.sv
// Multi-outstanding AES32 (saes32) XIF coprocessor: results are computed at accept time,
// parked in a DEPTH-entry ring with per-entry commit/kill state and retired in issue order.
module cv32e40x_xif_aes_buf #(
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFR_WIDTH = 32,
    parameter int DEPTH       = 4,
    parameter bit SAES_DEC_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst,
    if_xif.coproc_issue       xif_issue,
    if_xif.coproc_commit      xif_commit,
    if_xif.coproc_result      xif_result
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OPC_AES32 = 7'b0110011;
    localparam logic [4:0] F_ESI     = 5'b10001;
    localparam logic [4:0] F_ESMI    = 5'b10011;
    localparam logic [4:0] F_DSI     = 5'b10101;
    localparam logic [4:0] F_DSMI    = 5'b10111;

    typedef enum logic [1:0] {ST_FREE, ST_ISSUED, ST_COMMITTED, ST_KILLED} entry_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq = x;
        logic [7:0] r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] a;
        a = gf_inv(x);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
    endfunction

    entry_state_e             r_state [DEPTH];
    logic [X_ID_WIDTH-1:0]    r_id    [DEPTH];
    logic [4:0]               r_rd    [DEPTH];
    logic [X_RFR_WIDTH-1:0]   r_data  [DEPTH];
    logic [PTR_W-1:0]         r_head;
    logic [PTR_W-1:0]         r_tail;
    logic [CNT_W-1:0]         r_count;

    logic                     w_esi, w_esmi, w_dsi, w_dsmi, w_ours;
    logic                     w_full, w_ready, w_accept;
    logic [X_RFR_WIDTH-1:0]   w_dp_rs1, w_dp_rs2, w_result, w_mix, w_rot;
    logic [1:0]               w_dp_bs;
    logic [3:0]               w_dp_op;
    logic [7:0]               w_byte, w_fwd, w_inv;
    entry_state_e             w_new_state, w_head_state;
    logic                     w_head_valid, w_pop;
    logic                     w_unused_instr;

    assign w_esi  = xif_issue.issue_req_instr[29:25] == F_ESI;
    assign w_esmi = xif_issue.issue_req_instr[29:25] == F_ESMI;
    assign w_dsi  = SAES_DEC_EN && (xif_issue.issue_req_instr[29:25] == F_DSI);
    assign w_dsmi = SAES_DEC_EN && (xif_issue.issue_req_instr[29:25] == F_DSMI);
    assign w_ours = (xif_issue.issue_req_instr[6:0] == OPC_AES32) && (w_esi || w_esmi || w_dsi || w_dsmi);
    assign w_unused_instr = ^xif_issue.issue_req_instr[24:12];

    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_ready  = !rst && !w_full && (!w_ours || xif_issue.issue_req_rs_valid == 2'b11);
    assign w_accept = xif_issue.issue_valid && w_ready && w_ours;

    assign xif_issue.issue_ready          = w_ready;
    assign xif_issue.issue_resp_accept    = w_accept;
    assign xif_issue.issue_resp_writeback = w_accept;
    assign xif_issue.issue_resp_dualwrite = 1'b0;
    assign xif_issue.issue_resp_dualread  = 1'b0;
    assign xif_issue.issue_resp_loadstore = 1'b0;
    assign xif_issue.issue_resp_ecswrite  = 1'b0;
    assign xif_issue.issue_resp_exc       = 1'b0;

    // Operands are held at zero unless accepting so the S-box cone does not toggle on idle cycles.
    assign w_dp_rs1 = w_accept ? xif_issue.issue_req_rs[0] : '0;
    assign w_dp_rs2 = w_accept ? xif_issue.issue_req_rs[1] : '0;
    assign w_dp_bs  = w_accept ? xif_issue.issue_req_instr[31:30] : 2'b00;
    assign w_dp_op  = w_accept ? {w_dsmi, w_dsi, w_esmi, w_esi} : 4'b0000;

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_byte = 8'h00;
        w_mix  = '0;
        w_rot  = '0;
        case (w_dp_bs)
            2'd0: w_byte = w_dp_rs2[7:0];
            2'd1: w_byte = w_dp_rs2[15:8];
            2'd2: w_byte = w_dp_rs2[23:16];
            default: w_byte = w_dp_rs2[31:24];
        endcase
        w_fwd = sbox(w_byte);
        w_inv = inv_sbox(w_byte);
        case (w_dp_op)
            4'b0001: w_mix = {24'h0, w_fwd};
            4'b0010: w_mix = {gf_mul(w_fwd, 8'h03), w_fwd, w_fwd, xtime(w_fwd)};
            4'b0100: w_mix = {24'h0, w_inv};
            4'b1000: w_mix = {gf_mul(w_inv, 8'h0B), gf_mul(w_inv, 8'h0D),
                              gf_mul(w_inv, 8'h09), gf_mul(w_inv, 8'h0E)};
            default: w_mix = '0;
        endcase
        case (w_dp_bs)
            2'd0: w_rot = w_mix;
            2'd1: w_rot = {w_mix[23:0], w_mix[31:24]};
            2'd2: w_rot = {w_mix[15:0], w_mix[31:16]};
            default: w_rot = {w_mix[7:0], w_mix[31:8]};
        endcase
        w_result = w_dp_rs1 ^ w_rot;
    end

    // A commit for the id being accepted this cycle lands on the new entry directly.
    always_comb begin
        w_new_state = ST_ISSUED;
        if (xif_commit.commit_valid && xif_commit.commit_id == xif_issue.issue_req_id)
            w_new_state = xif_commit.commit_kill ? ST_KILLED : ST_COMMITTED;
    end

    assign w_head_state = r_state[r_head];
    assign w_head_valid = !rst && (w_head_state == ST_COMMITTED);
    assign w_pop        = (w_head_valid && xif_result.result_ready) || (w_head_state == ST_KILLED);

    assign xif_result.result_valid = w_head_valid;
    assign xif_result.result_id    = w_head_valid ? r_id[r_head]   : '0;
    assign xif_result.result_data  = w_head_valid ? r_data[r_head] : '0;
    assign xif_result.result_rd    = w_head_valid ? r_rd[r_head]   : 5'd0;
    assign xif_result.result_we    = 1'b1;

    // NOTE: only the entry states are reset; id/rd/data are don't-care while FREE and stay reset-free.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_state[i] <= ST_FREE;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignments; later writes below win on the same entry.
            for (int i = 0; i < DEPTH; i++) begin
                if (xif_commit.commit_valid && r_state[i] == ST_ISSUED && r_id[i] == xif_commit.commit_id)
                    r_state[i] <= xif_commit.commit_kill ? ST_KILLED : ST_COMMITTED;
            end
            if (w_pop) begin
                r_state[r_head] <= ST_FREE;
                r_head          <= r_head + 1'b1;
            end
            if (w_accept) begin
                r_state[r_tail] <= w_new_state;
                r_id[r_tail]    <= xif_issue.issue_req_id;
                r_rd[r_tail]    <= xif_issue.issue_req_instr[11:7];
                r_data[r_tail]  <= w_result;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_accept && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_accept && w_pop)
                r_count <= r_count - 1'b1;
        end
    end
endmodule

// File: tb/tb_cv32e40x_xif_aes_buf.sv
// Directed bench for cv32e40x_xif_aes_buf: hand-computed AES32 results, ordering, kill drain,
// operand wait, decrypt-disabled build and mid-flight reset.
module tb_cv32e40x_xif_aes_buf;
    localparam logic [4:0] F_ESI  = 5'b10001;
    localparam logic [4:0] F_ESMI = 5'b10011;
    localparam logic [4:0] F_DSI  = 5'b10101;
    localparam logic [4:0] F_DSMI = 5'b10111;

    logic clk_i = 1'b0;
    logic rst   = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    if_xif #(.X_ID_WIDTH(4), .X_RFR_WIDTH(32)) xa ();
    if_xif #(.X_ID_WIDTH(4), .X_RFR_WIDTH(32)) xb ();

    cv32e40x_xif_aes_buf #(.X_ID_WIDTH(4), .X_RFR_WIDTH(32), .DEPTH(4), .SAES_DEC_EN(1'b1)) dut (
        .clk_i      (clk_i),
        .rst        (rst),
        .xif_issue  (xa.coproc_issue),
        .xif_commit (xa.coproc_commit),
        .xif_result (xa.coproc_result)
    );

    cv32e40x_xif_aes_buf #(.X_ID_WIDTH(4), .X_RFR_WIDTH(32), .DEPTH(4), .SAES_DEC_EN(1'b0)) dut_nodec (
        .clk_i      (clk_i),
        .rst        (rst),
        .xif_issue  (xb.coproc_issue),
        .xif_commit (xb.coproc_commit),
        .xif_result (xb.coproc_result)
    );

    function automatic logic [31:0] mk(input logic [4:0] f5, input logic [1:0] bs, input logic [4:0] rd);
        return {bs, f5, 5'd2, 5'd1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_a();
        xa.issue_valid  = 1'b0;
        xa.commit_valid = 1'b0;
        xa.commit_kill  = 1'b0;
    endtask

    task automatic drive_a(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [3:0] id, input bit do_commit, input bit kill);
        xa.issue_valid        = 1'b1;
        xa.issue_req_instr    = instr;
        xa.issue_req_rs[0]    = rs1;
        xa.issue_req_rs[1]    = rs2;
        xa.issue_req_rs_valid = 2'b11;
        xa.issue_req_id       = id;
        xa.commit_valid       = do_commit;
        xa.commit_id          = id;
        xa.commit_kill        = kill;
    endtask

    task automatic commit_a(input logic [3:0] id, input bit kill);
        xa.issue_valid  = 1'b0;
        xa.commit_valid = 1'b1;
        xa.commit_id    = id;
        xa.commit_kill  = kill;
    endtask

    // Issue with a same-cycle commit, then expect the result on the following cycle.
    task automatic run_single(input string tag, input logic [31:0] instr, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [3:0] id, input logic [4:0] rd,
                              input logic [31:0] expected);
        drive_a(instr, rs1, rs2, id, 1'b1, 1'b0);
        @(negedge clk_i);
        check({tag, "_accept"}, 32'(xa.issue_resp_accept), 32'd1);
        next_cycle();
        idle_a();
        @(negedge clk_i);
        check({tag, "_valid"}, 32'(xa.result_valid), 32'd1);
        check({tag, "_data"}, xa.result_data, expected);
        check({tag, "_rd"}, 32'(xa.result_rd), 32'(rd));
        check({tag, "_id"}, 32'(xa.result_id), 32'(id));
        next_cycle();
    endtask

    initial begin
        idle_a();
        xa.issue_req_instr    = 32'h0;
        xa.issue_req_rs[0]    = 32'h0;
        xa.issue_req_rs[1]    = 32'h0;
        xa.issue_req_rs_valid = 2'b11;
        xa.issue_req_id       = 4'd0;
        xa.commit_id          = 4'd0;
        xa.result_ready       = 1'b1;
        xb.issue_valid        = 1'b0;
        xb.issue_req_instr    = 32'h0;
        xb.issue_req_rs[0]    = 32'h0;
        xb.issue_req_rs[1]    = 32'h0;
        xb.issue_req_rs_valid = 2'b11;
        xb.issue_req_id       = 4'd0;
        xb.commit_valid       = 1'b0;
        xb.commit_id          = 4'd0;
        xb.commit_kill        = 1'b0;
        xb.result_ready       = 1'b1;

        // Reset: a valid request must not be accepted, result channel quiet.
        next_cycle();
        drive_a(mk(F_ESI, 2'd0, 5'd1), 32'h0, 32'h0, 4'd1, 1'b1, 1'b0);
        @(negedge clk_i);
        check("rst_issue_ready", 32'(xa.issue_ready), 32'd0);
        check("rst_accept", 32'(xa.issue_resp_accept), 32'd0);
        check("rst_writeback", 32'(xa.issue_resp_writeback), 32'd0);
        check("rst_result_valid", 32'(xa.result_valid), 32'd0);
        check("rst_result_id", 32'(xa.result_id), 32'd0);
        check("rst_result_data", xa.result_data, 32'd0);
        check("rst_result_rd", 32'(xa.result_rd), 32'd0);
        check("rst_result_we", 32'(xa.result_we), 32'd1);
        next_cycle();
        rst = 1'b0;
        idle_a();
        @(negedge clk_i);
        check("post_rst_issue_ready", 32'(xa.issue_ready), 32'd1);
        check("post_rst_count", 32'(dut.r_count), 32'd0);
        check("post_rst_result_valid", 32'(xa.result_valid), 32'd0);
        next_cycle();

        // Datapath vectors.
        run_single("esi0",   mk(F_ESI,  2'd0, 5'd5), 32'h0,        32'h0,        4'd3, 5'd5, 32'h0000_0063);
        run_single("esmi0",  mk(F_ESMI, 2'd0, 5'd6), 32'h0,        32'h0,        4'd4, 5'd6, 32'hA563_63C6);
        run_single("esi_bs2", mk(F_ESI, 2'd2, 5'd7), 32'hFFFF_FFFF, 32'h0,       4'd5, 5'd7, 32'hFF9C_FFFF);
        run_single("dsi0",   mk(F_DSI,  2'd0, 5'd8), 32'h0,        32'h0,        4'd6, 5'd8, 32'h0000_0052);
        run_single("dsmi0",  mk(F_DSMI, 2'd0, 5'd9), 32'h0,        32'h0,        4'd7, 5'd9, 32'h50A7_F451);
        run_single("esi_bs1", mk(F_ESI, 2'd1, 5'd10), 32'h1234_5678, 32'h0000_1100, 4'd8, 5'd10, 32'h1234_D478);

        // Fill with result_ready low, then drain in order.
        xa.result_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_a(mk(F_ESI, 2'd0, 5'd1), 32'(i), 32'h0, 4'(i), 1'b1, 1'b0);
            @(negedge clk_i);
            check("fill_accept", 32'(xa.issue_resp_accept), 32'd1);
            next_cycle();
        end
        drive_a(mk(F_ESI, 2'd0, 5'd1), 32'h0, 32'h0, 4'd4, 1'b0, 1'b0);
        @(negedge clk_i);
        check("full_issue_ready", 32'(xa.issue_ready), 32'd0);
        check("full_accept", 32'(xa.issue_resp_accept), 32'd0);
        check("full_head_id", 32'(xa.result_id), 32'd0);
        next_cycle();
        idle_a();
        xa.result_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("drain_valid", 32'(xa.result_valid), 32'd1);
            check("drain_id", 32'(xa.result_id), 32'(i));
            check("drain_data", xa.result_data, 32'h63 ^ 32'(i));
            if (i == 0) check("full_pop_ready", 32'(xa.issue_ready), 32'd0);
            if (i == 1) check("after_pop_ready", 32'(xa.issue_ready), 32'd1);
            next_cycle();
        end
        @(negedge clk_i);
        check("drain_empty", 32'(xa.result_valid), 32'd0);
        next_cycle();

        // Kill hole: ids 1,2,3; commit 2, kill 1, commit 3.
        for (int i = 1; i < 4; i++) begin
            drive_a(mk(F_ESI, 2'd0, 5'd2), 32'(i), 32'h0, 4'(i), 1'b0, 1'b0);
            next_cycle();
        end
        commit_a(4'd2, 1'b0);
        @(negedge clk_i);
        check("hole_c2_valid", 32'(xa.result_valid), 32'd0);
        next_cycle();
        commit_a(4'd1, 1'b1);
        @(negedge clk_i);
        check("hole_stall_valid", 32'(xa.result_valid), 32'd0);
        next_cycle();
        commit_a(4'd3, 1'b0);
        @(negedge clk_i);
        check("hole_killed_silent", 32'(xa.result_valid), 32'd0);
        next_cycle();
        idle_a();
        @(negedge clk_i);
        check("hole_r2_valid", 32'(xa.result_valid), 32'd1);
        check("hole_r2_id", 32'(xa.result_id), 32'd2);
        check("hole_r2_data", xa.result_data, 32'h0000_0061);
        next_cycle();
        @(negedge clk_i);
        check("hole_r3_valid", 32'(xa.result_valid), 32'd1);
        check("hole_r3_id", 32'(xa.result_id), 32'd3);
        next_cycle();
        @(negedge clk_i);
        check("hole_done", 32'(xa.result_valid), 32'd0);
        check("hole_count", 32'(dut.r_count), 32'd0);
        next_cycle();

        // Operand wait, then a non-AES request that handshakes without accept.
        drive_a(mk(F_ESI, 2'd0, 5'd3), 32'h0, 32'h0, 4'd9, 1'b1, 1'b0);
        xa.issue_req_rs_valid = 2'b01;
        #1;
        check("opwait_ready", 32'(xa.issue_ready), 32'd0);
        check("opwait_accept", 32'(xa.issue_resp_accept), 32'd0);
        xa.issue_req_rs_valid = 2'b11;
        @(negedge clk_i);
        check("opok_accept", 32'(xa.issue_resp_accept), 32'd1);
        next_cycle();
        idle_a();
        @(negedge clk_i);
        check("opok_result_id", 32'(xa.result_id), 32'd9);
        next_cycle();
        drive_a(32'h0010_0093, 32'h0, 32'h0, 4'd10, 1'b1, 1'b0);
        @(negedge clk_i);
        check("notours_ready", 32'(xa.issue_ready), 32'd1);
        check("notours_accept", 32'(xa.issue_resp_accept), 32'd0);
        next_cycle();
        idle_a();

        // Decrypt disabled: DSMI is not ours.
        xb.issue_valid     = 1'b1;
        xb.issue_req_instr = mk(F_DSMI, 2'd0, 5'd4);
        xb.issue_req_id    = 4'd2;
        xb.commit_valid    = 1'b1;
        xb.commit_id       = 4'd2;
        @(negedge clk_i);
        check("nodec_ready", 32'(xb.issue_ready), 32'd1);
        check("nodec_accept", 32'(xb.issue_resp_accept), 32'd0);
        next_cycle();
        xb.issue_valid  = 1'b0;
        xb.commit_valid = 1'b0;
        @(negedge clk_i);
        check("nodec_no_result", 32'(xb.result_valid), 32'd0);
        check("nodec_count", 32'(dut_nodec.r_count), 32'd0);
        next_cycle();

        // Reset with three committed entries stalled.
        xa.result_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_a(mk(F_ESI, 2'd0, 5'd1), 32'h0, 32'h0, 4'(i + 11), 1'b1, 1'b0);
            next_cycle();
        end
        idle_a();
        @(negedge clk_i);
        check("mid_pre_valid", 32'(xa.result_valid), 32'd1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk_i);
        check("mid_rst_valid", 32'(xa.result_valid), 32'd0);
        check("mid_rst_ready", 32'(xa.issue_ready), 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk_i);
        check("mid_post_valid", 32'(xa.result_valid), 32'd0);
        check("mid_post_count", 32'(dut.r_count), 32'd0);
        xa.result_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk_i);
            check("mid_no_stale", 32'(xa.result_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
